// File: rtl/adder_pkg.sv
// Shared types and defaults for the A+B adder front-end.
package adder_pkg;

    localparam int unsigned OPERAND_W               = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HAVE_A  = 2'd1,
        HAVE_AB = 2'd2
    } state_t;

endpackage

// File: rtl/key_conditioner.sv
// Active-low pushbutton to one-cycle press strobe: 2-FF sync, optional debounce
// (OPERAND_LOADER_DEBOUNCE_EN), registered falling-edge detect.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       level;
    logic       hist_q;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

    logic            filt_q;
    logic [CntW-1:0] cnt_q;

    // Level is accepted on the cycle the counter would reach DEBOUNCE_CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_q[1] == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            filt_q <= sync_q[1];
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b1;
            pulse  <= 1'b0;
        end else begin
            hist_q <= level;
            pulse  <= hist_q & ~level;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Two-press operand capture FSM feeding the adder; keys conditioned on CLK.
// Debounce is enabled by defining OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader
    import adder_pkg::*;
#(
    parameter int unsigned N               = OPERAND_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [N-1:0] SW,
    input  logic         KEY_LOAD_n,
    input  logic         KEY_CLR_n,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic         valid,
    output logic [1:0]   state_o,
    output logic         load_pulse
);

    state_t state_q;
    logic   clr_pulse;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_load (
        .clk   (CLK),
        .reset (reset),
        .key_n (KEY_LOAD_n),
        .pulse (load_pulse)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_clr (
        .clk   (CLK),
        .reset (reset),
        .key_n (KEY_CLR_n),
        .pulse (clr_pulse)
    );

    // Clear takes priority over a coincident load, which is dropped.
    always_ff @(posedge CLK) begin
        if (reset || clr_pulse) begin
            state_q <= EMPTY;
            op_a    <= '0;
            op_b    <= '0;
            valid   <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load_pulse) begin
                        op_a    <= SW;
                        state_q <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (load_pulse) begin
                        op_b    <= SW;
                        state_q <= HAVE_AB;
                        valid   <= 1'b1;
                    end
                end
                HAVE_AB: begin
                    if (load_pulse) begin
                        op_a    <= SW;
                        state_q <= HAVE_A;
                        valid   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader; works with or without OPERAND_LOADER_DEBOUNCE_EN.
module tb_operand_loader;

    localparam int unsigned DB = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int LAT        = DB;
    localparam int ACCEPT_MIN = DB;
`else
    localparam int LAT        = 0;
    localparam int ACCEPT_MIN = 1;
`endif

    typedef struct {
        int         edge_at;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] st;
    } exp_t;

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] SW;
    logic       KEY_LOAD_n;
    logic       KEY_CLR_n;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       valid;
    logic [1:0] state_o;
    logic       load_pulse;

    int   edge_cnt     = 0;
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   n_pulses     = 0;
    int   n_exp_pulses = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   chk_pending  = 1'b0;

    logic [7:0] m_a  = '0;
    logic [7:0] m_b  = '0;
    logic [1:0] m_st = 2'd0;

    operand_loader #(
        .N(8),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .SW         (SW),
        .KEY_LOAD_n (KEY_LOAD_n),
        .KEY_CLR_n  (KEY_CLR_n),
        .op_a       (op_a),
        .op_b       (op_b),
        .valid      (valid),
        .state_o    (state_o),
        .load_pulse (load_pulse)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic model_load(input logic [7:0] sw);
        case (m_st)
            2'd0: begin m_a = sw; m_st = 2'd1; end
            2'd1: begin m_b = sw; m_st = 2'd2; end
            default: begin m_a = sw; m_st = 2'd1; end
        endcase
    endtask

    task automatic push_exp(input int edge_at);
        exp_t e;
        e.edge_at = edge_at;
        e.a       = m_a;
        e.b       = m_b;
        e.st      = m_st;
        exp_q.push_back(e);
        n_exp_pulses++;
    endtask

    // Drive keys low for `hold` sampled edges, then release and let it settle.
    task automatic press(input logic [7:0] sw, input int hold, input bit do_load,
                         input bit do_clr);
        @(negedge CLK);
        SW = sw;
        if (do_load) KEY_LOAD_n = 1'b0;
        if (do_clr)  KEY_CLR_n  = 1'b0;
        if (hold >= ACCEPT_MIN) begin
            if (do_clr) begin
                m_a = '0; m_b = '0; m_st = 2'd0;
            end else if (do_load) begin
                model_load(sw);
            end
            if (do_load) push_exp(edge_cnt + 3 + LAT);
        end
        repeat (hold) @(negedge CLK);
        KEY_LOAD_n = 1'b1;
        KEY_CLR_n  = 1'b1;
        repeat (LAT + 8) @(negedge CLK);
        check_eq("pulse_drained", 32'(exp_q.size()), 32'd0);
        check_eq("state_after", {30'd0, state_o}, {30'd0, m_st});
    endtask

    always @(negedge CLK) begin
        if (chk_pending) begin
            check_eq("op_a", {24'd0, op_a}, {24'd0, cur.a});
            check_eq("op_b", {24'd0, op_b}, {24'd0, cur.b});
            check_eq("state_o", {30'd0, state_o}, {30'd0, cur.st});
            check_eq("valid", {31'd0, valid}, {31'd0, cur.st == 2'd2});
            chk_pending = 1'b0;
        end
        if (!reset && load_pulse) begin
            n_pulses++;
            check_eq("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check_eq("pulse_edge", edge_cnt, cur.edge_at);
                chk_pending = 1'b1;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        SW         = '0;
        KEY_LOAD_n = 1'b1;
        KEY_CLR_n  = 1'b1;
        repeat (2) @(negedge CLK);
        check_eq("rst_op_a", {24'd0, op_a}, 32'd0);
        check_eq("rst_op_b", {24'd0, op_b}, 32'd0);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_state", {30'd0, state_o}, 32'd0);
        check_eq("rst_pulse", {31'd0, load_pulse}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge CLK);

        press(8'h3C, 10, 1'b1, 1'b0);
        press(8'hA5, 10, 1'b1, 1'b0);
        check_eq("two_load_pulses", n_pulses, 2);
        check_eq("two_valid", {31'd0, valid}, 32'd1);

        press(8'hFF, 10, 1'b1, 1'b0);
        check_eq("third_op_b", {24'd0, op_b}, 32'h0000_00A5);

        press(8'h77, 10, 1'b1, 1'b1);
        check_eq("simul_op_a", {24'd0, op_a}, 32'd0);

        press(8'h5A, 3, 1'b1, 1'b0);

        // Reset while the load key is held part-way through conditioning.
        @(negedge CLK);
        SW         = 8'hC3;
        KEY_LOAD_n = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        m_a  = '0;
        m_b  = '0;
        m_st = 2'd0;
        model_load(8'hC3);
        push_exp(edge_cnt + 3 + LAT);
        repeat (LAT + 8) @(negedge CLK);
        KEY_LOAD_n = 1'b1;
        repeat (LAT + 8) @(negedge CLK);
        check_eq("rstmid_drained", 32'(exp_q.size()), 32'd0);
        check_eq("rstmid_op_a", {24'd0, op_a}, 32'h0000_00C3);
        check_eq("rstmid_state", {30'd0, state_o}, 32'd1);

        check_eq("total_pulses", n_pulses, n_exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
